// File: rtl/scroll_msg_pkg.sv
// Character codes and 7-segment patterns shared by the scrolling message display.
// Segment bit order is {dp,g,f,e,d,c,b,a}, active-high; dp is never lit.
package scroll_msg_pkg;

   localparam logic [5:0] CH_0     = 6'd0;
   localparam logic [5:0] CH_A     = 6'd10;
   localparam logic [5:0] CH_BLANK = 6'd36;
   localparam int         NUM_CHARS = 36;

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // 0-9 followed by A-Z; letters that cannot be drawn cleanly use the closest shape
   localparam logic [7:0] SEG_LUT [NUM_CHARS] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F,
      8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71, 8'h3D, 8'h76, 8'h30, 8'h1E,
      8'h75, 8'h38, 8'h55, 8'h54, 8'h3F, 8'h73, 8'h67, 8'h50, 8'h6D, 8'h78,
      8'h3E, 8'h1C, 8'h2A, 8'h76, 8'h6E, 8'h5B
   };

endpackage

// File: rtl/seg7_char_dec.sv
// Combinational character-code to 7-segment decoder; unknown codes blank the digit.
module seg7_char_dec
   import scroll_msg_pkg::*;
(
   input  logic [5:0] code,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      if (code < 6'(NUM_CHARS)) seg = SEG_LUT[code];
   end

endmodule

// File: rtl/scroll_msg_mux.sv
// Multiplexed 7-segment driver showing a window of a scrolling message buffer.
// Define SCROLL_PAUSE_EN to hold the window at offset 0 for PAUSE_TICKS scroll ticks after each wrap.
module scroll_msg_mux
   import scroll_msg_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int MSG_LEN     = 16,
   parameter int REFRESH_DIV = 100000,
   parameter int SCROLL_DIV  = 100,
   parameter int PAUSE_TICKS = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         wr_en,
   input  logic [$clog2(MSG_LEN)-1:0]   wr_addr,
   input  logic [5:0]                   wr_data,
   input  logic [$clog2(MSG_LEN):0]     msg_len,
   input  logic                         scroll_en,
   output logic [NUM_DIGITS-1:0]        sel,
   output logic [7:0]                   seg,
   output logic                         wrap
);

   localparam int AW  = $clog2(MSG_LEN);
   localparam int LW  = AW + 1;
   localparam int DW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
   localparam int IW  = ((AW > DW) ? AW : DW) + 2;

   logic [RW-1:0]  ref_cnt;
   logic [SCW-1:0] scr_cnt;
   logic [DW-1:0]  dig;
   logic [AW-1:0]  offset;
   logic [5:0]     buffer [MSG_LEN];

   logic           ref_tick, scroll_tick, offset_bad, paused, wrap_now;
   logic [IW-1:0]  rd_sum, rd_pos;
   logic [5:0]     rd_code;
   logic [7:0]     dec_seg;

   assign ref_tick    = (ref_cnt == RW'(REFRESH_DIV - 1));
   assign scroll_tick = ref_tick && scroll_en && (scr_cnt == SCW'(SCROLL_DIV - 1));
   assign offset_bad  = (LW'(offset) >= msg_len);
   assign wrap_now    = scroll_tick && !paused && !offset_bad &&
                        (LW'(offset) + LW'(1) >= msg_len);

   // True modulo so short messages repeat across all digits
   always_comb begin
      rd_sum  = IW'(offset) + IW'(dig);
      rd_pos  = '0;
      rd_code = CH_BLANK;
      if (msg_len != '0) begin
         rd_pos = rd_sum % IW'(msg_len);
         if (rd_pos < IW'(MSG_LEN)) rd_code = buffer[rd_pos[AW-1:0]];
      end
   end

   seg7_char_dec u_dec (
      .code (rd_code),
      .seg  (dec_seg)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MSG_LEN; i++) buffer[i] <= CH_BLANK;
      end else if (wr_en && (int'(wr_addr) < MSG_LEN)) begin
         buffer[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ref_cnt <= '0;
         dig     <= '0;
         sel     <= '0;
         seg     <= '0;
      end else if (ref_tick) begin
         ref_cnt <= '0;
         sel     <= NUM_DIGITS'(1) << dig;
         seg     <= dec_seg;
         dig     <= (dig == DW'(NUM_DIGITS - 1)) ? '0 : dig + DW'(1);
      end else begin
         ref_cnt <= ref_cnt + RW'(1);
      end
   end

   // A shrinking msg_len snaps the window home silently; only a real scroll wrap pulses
   always_ff @(posedge clk) begin
      wrap <= 1'b0;
      if (rst) begin
         scr_cnt <= '0;
         offset  <= '0;
      end else begin
         if (ref_tick && scroll_en) scr_cnt <= scroll_tick ? '0 : scr_cnt + SCW'(1);
         if (offset_bad) begin
            offset <= '0;
         end else if (wrap_now) begin
            offset <= '0;
            wrap   <= 1'b1;
         end else if (scroll_tick && !paused) begin
            offset <= offset + AW'(1);
         end
      end
   end

`ifdef SCROLL_PAUSE_EN
   localparam int PW = (PAUSE_TICKS > 0) ? $clog2(PAUSE_TICKS + 1) : 1;

   logic [PW-1:0] pause_cnt;

   assign paused = (pause_cnt != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pause_cnt <= '0;
      end else if (scroll_tick) begin
         if (paused)        pause_cnt <= pause_cnt - PW'(1);
         else if (wrap_now) pause_cnt <= PW'(PAUSE_TICKS);
      end
   end
`else
   assign paused = 1'b0;
`endif

endmodule
